serdes_serializer: RTL



---
 rtl/serdes_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serdes_serializer.sv
// serdes_serializer: parallel-to-serial transmitter for the serdes link.
//
// Accepts WIDTH-bit words on a valid/ready handshake into a one-word holding
// register, then shifts each word out one bit per clock on ser_out. A word
// waiting in the holding register is started immediately after the previous
// word's final bit, so back-to-back words stream without an idle cycle.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   data_in     word to transmit, captured on accept
//   data_valid  data_in holds a valid word
//   data_ready  holding register empty (accept = data_valid && data_ready)
//   ser_out     registered serial bit stream
//   ser_frame   high while ser_out carries a word bit (or parity bit)
//   ser_last    high during the final bit period of a word
//   busy        transmitter active or holding register occupied
//
// Build option:
//   SERDES_SERIALIZER_PARITY_EN  appends one even-parity bit after each word;
//                                ser_last then marks the parity bit.

module serdes_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

`ifdef SERDES_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_frame_q, ser_frame_d;
    logic             ser_last_q, ser_last_d;
`ifdef SERDES_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept;
    logic load;
    logic last_bit;

    always_comb begin
        accept   = data_valid && !hold_full_q;
        last_bit = (bitcnt_q == CW'(WIDTH - 1));
        load     = 1'b0;

        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        ser_out_d   = 1'b0;
        ser_frame_d = 1'b0;
        ser_last_d  = 1'b0;
`ifdef SERDES_SERIALIZER_PARITY_EN
        par_d       = par_q;
`endif

        // accept only happens with hold empty, load only with hold full,
        // so the two never fight over hold_full_d
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef SERDES_SERIALIZER_PARITY_EN
                    state_d     = PARITY;
                    ser_out_d   = par_q;
                    ser_frame_d = 1'b1;
                    ser_last_d  = 1'b1;
`else
                    if (hold_full_q) load = 1'b1;
                    else             state_d = IDLE;
`endif
                end else begin
                    ser_out_d   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    bitcnt_d    = bitcnt_q + 1'b1;
                    ser_frame_d = 1'b1;
`ifndef SERDES_SERIALIZER_PARITY_EN
                    ser_last_d  = (bitcnt_d == CW'(WIDTH - 1));
`endif
                end
            end
`ifdef SERDES_SERIALIZER_PARITY_EN
            PARITY: begin
                if (hold_full_q) load = 1'b1;
                else             state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // shreg keeps only the bits not yet sent; the first bit goes straight
        // to ser_out so a reload right after the last bit leaves no gap
        if (load) begin
            ser_out_d   = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
            shreg_d     = MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
            bitcnt_d    = '0;
            ser_frame_d = 1'b1;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
`ifdef SERDES_SERIALIZER_PARITY_EN
            par_d       = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            ser_last_q  <= 1'b0;
`ifdef SERDES_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            ser_last_q  <= ser_last_d;
`ifdef SERDES_SERIALIZER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign data_ready = !hold_full_q;
    assign ser_out    = ser_out_q;
    assign ser_frame  = ser_frame_q;
    assign ser_last   = ser_last_q;
    assign busy       = (state_q != IDLE) || hold_full_q;

endmodule
